mem_port_arbiter: RTL and testbench

- Arbitrates one single-port unified memory between the instruction-fetch requester and the load/store requester of the riscv core.
- Issues one transaction at a time and tracks read latency.
- Returns read data to the winning requester and drives a stall signal for the pipeline.
- Data requester has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/read-data bundle shared by the fetch requester, the load/store
// requester and the single-port memory behind mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_size;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_size;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_size
    );

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one single-port memory, one outstanding read.
// Optional stall-cycle counter enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus,
    output logic                  stall_o,
    output logic [31:0]           perf_stall_cnt
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_MAX);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             owner_if_q, owner_if_d;
    logic [SC_W-1:0]  starve_q, starve_d;

    logic rd_done, arb_ok, fetch_win, data_win;

    assign rd_done   = (state_q == RD_WAIT) && (lat_q == LAT_LAST);
    assign arb_ok    = (state_q == IDLE) || rd_done;
    assign fetch_win = arb_ok && bus.if_req && (!bus.d_req || (starve_q == SC_MAX));
    assign data_win  = arb_ok && bus.d_req && !fetch_win;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_if_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            owner_if_q <= owner_if_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        owner_if_d = owner_if_q;
        starve_d   = starve_q;

        if (state_q == RD_WAIT)
            lat_d = lat_q + LAT_W'(1);

        // A grant in the final wait cycle starts the next read back-to-back
        if (fetch_win || (data_win && !bus.d_we)) begin
            state_d    = RD_WAIT;
            lat_d      = LAT_W'(1);
            owner_if_d = fetch_win;
        end else if (rd_done) begin
            state_d = IDLE;
            lat_d   = '0;
        end

        if (!bus.if_req || fetch_win)
            starve_d = '0;
        else if (data_win && (starve_q != SC_MAX))
            starve_d = starve_q + SC_W'(1);
    end

    logic if_rv, d_rv;

    always_comb begin
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        if_rv         = 1'b0;
        d_rv          = 1'b0;
        stall_o       = 1'b0;

        // Every output is forced low while reset is held
        if (rst) begin
            bus.if_gnt = fetch_win;
            bus.d_gnt  = data_win;
            bus.mem_en = fetch_win || data_win;
            if (fetch_win) begin
                bus.mem_addr = bus.if_addr;
                bus.mem_size = 3'b010;
            end else if (data_win) begin
                bus.mem_we    = bus.d_we;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.mem_size  = bus.d_size;
            end
            if_rv   = rd_done && owner_if_q;
            d_rv    = rd_done && !owner_if_q;
            stall_o = (bus.if_req && !fetch_win) || (bus.d_req && !data_win) ||
                      ((state_q == RD_WAIT) && !rd_done);
        end
    end

    assign bus.if_rvalid = if_rv;
    assign bus.d_rvalid  = d_rv;
    assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
    assign bus.d_rdata   = d_rv  ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst)
            perf_q <= '0;
        else if (stall_o)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_cnt = rst ? perf_q : '0;
`else
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle-numbered reference model queues
// per-cycle expectations and read returns; a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_o;
    logic [31:0] perf;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .stall_o(stall_o), .perf_stall_cnt(perf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        all0;
        logic        if_gnt, d_gnt, mem_en, mem_we, if_rv, d_rv, stall;
        logic [31:0] addr, wdata, perf;
        logic [2:0]  size;
    } exp_t;

    typedef struct {
        bit          own_if;
        logic [31:0] data;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: cycle number of the pending read return (-1 = none)
    int          cyc = 0;
    int          rd_due = -1;
    bit          rd_own_if;
    logic [31:0] rd_data;
    int          starve = 0;
    logic [31:0] perf_m = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic step(input bit rv, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [2:0] ds,
                        output bit fw, output bit dwn);
        exp_t e;
        bit   done, arb;
        rd_t  r;
        @(posedge clk);
        #1;
        rst         = rv;
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_size  = ds;
        e = '{default: '0};
        fw = 1'b0;
        dwn = 1'b0;
        if (!rv) begin
            e.all0 = 1'b1;
            rd_q.delete();
            rd_due = -1;
            starve = 0;
            perf_m = '0;
            bus.mem_rdata = $urandom;
        end else begin
            done = (rd_due == cyc);
            arb  = (rd_due < 0) || done;
            fw   = arb && ir && (!dr || starve == STARVE_MAX);
            dwn  = arb && dr && !fw;
            e.if_gnt = fw;
            e.d_gnt  = dwn;
            e.mem_en = fw || dwn;
            if (fw) begin
                e.addr = ia;
                e.size = 3'b010;
            end else if (dwn) begin
                e.addr   = da;
                e.wdata  = dwd;
                e.size   = ds;
                e.mem_we = dw;
            end
            e.if_rv = done && rd_own_if;
            e.d_rv  = done && !rd_own_if;
            bus.mem_rdata = done ? rd_data : $urandom;
            e.stall = (ir && !fw) || (dr && !dwn) || (rd_due >= 0 && !done);
`ifdef ARB_PERF_CNT_EN
            e.perf = perf_m;
`endif
            perf_m = perf_m + 32'(e.stall);
            if (!ir || fw)
                starve = 0;
            else if (dwn && starve < STARVE_MAX)
                starve++;
            if (fw || (dwn && !dw)) begin
                rd_due    = cyc + MEM_LAT;
                rd_own_if = fw;
                rd_data   = $urandom;
                r.own_if  = fw;
                r.data    = rd_data;
                rd_q.push_back(r);
            end else if (done) begin
                rd_due = -1;
            end
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int n);
        bit fw, dwn;
        for (int k = 0; k < n; k++)
            step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fw, dwn);
    endtask

    // Hold the given requests until each has been granted
    task automatic issue(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] ds);
        bit fw, dwn;
        for (int k = 0; k < 16 && (ir || dr); k++) begin
            step(1'b1, ir, ia, dr, dw, da, dwd, ds, fw, dwn);
            if (fw) ir = 1'b0;
            if (dwn) dr = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        rd_t  r;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("if_gnt", 32'(bus.if_gnt), 32'(e.if_gnt));
                chk("d_gnt", 32'(bus.d_gnt), 32'(e.d_gnt));
                chk("mem_en", 32'(bus.mem_en), 32'(e.mem_en));
                chk("stall_o", 32'(stall_o), 32'(e.stall));
                chk("if_rvalid", 32'(bus.if_rvalid), 32'(e.if_rv));
                chk("d_rvalid", 32'(bus.d_rvalid), 32'(e.d_rv));
                chk("perf_stall_cnt", perf, e.perf);
                if (e.mem_en || e.all0) begin
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_size", 32'(bus.mem_size), 32'(e.size));
                    chk("mem_we", 32'(bus.mem_we), 32'(e.mem_we));
                end
                if (e.d_gnt || e.all0)
                    chk("mem_wdata", bus.mem_wdata, e.wdata);
            end
            if (bus.if_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rvalid_unexpected: got rvalid, expected no read outstanding (t=%0t)", $time);
                end else begin
                    r = rd_q.pop_front();
                    chk("rvalid_owner_if", 32'(bus.if_rvalid), 32'(r.own_if));
                    chk("rvalid_owner_d", 32'(bus.d_rvalid), 32'(!r.own_if));
                    chk("rdata", r.own_if ? bus.if_rdata : bus.d_rdata, r.data);
                    chk("nonowner_rdata", r.own_if ? bus.d_rdata : bus.if_rdata, '0);
                end
            end else begin
                chk("if_rdata_idle", bus.if_rdata, '0);
                chk("d_rdata_idle", bus.d_rdata, '0);
            end
        end
    end

    initial begin : driver
        bit          fw, dwn, hi, hd, dw, rv;
        logic [31:0] ia, da, dwd;
        logic [2:0]  ds;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0; bus.mem_rdata = '0;

        for (int k = 0; k < 2; k++)
            step(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, '0, 3'b010, fw, dwn);

        issue(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
        idle(MEM_LAT + 1);
        issue(1'b1, 32'h20, 1'b1, 1'b0, 32'h80, '0, 3'b010);
        idle(MEM_LAT + 1);
        // Fetch held against back-to-back loads: starvation limit must let it through
        hi = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, hi, 32'h30, 1'b1, 1'b0, 32'h100 + 32'(k * 4), '0, 3'b110, fw, dwn);
            if (fw) hi = 1'b0;
        end
        idle(MEM_LAT + 1);
        issue(1'b1, 32'h44, 1'b1, 1'b1, 32'h40, 32'h12345678, 3'b010);
        idle(MEM_LAT + 1);
        step(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, '0, '0, '0, fw, dwn);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, fw, dwn);
        idle(MEM_LAT + 1);
        issue(1'b1, 32'h60, 1'b0, 1'b0, '0, '0, '0);
        idle(MEM_LAT + 1);

        hi = 1'b0; hd = 1'b0; ia = '0; da = '0; dwd = '0; ds = '0; dw = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            int dense;
            dense = (i < 1000) ? 3 : 1;
            if (!hi && int'($urandom % 4) < dense) begin
                hi = 1'b1;
                ia = $urandom & 32'h0000_fffc;
            end else if (hi && ($urandom % 32) == 0) begin
                hi = 1'b0;
            end
            if (!hd && int'($urandom % 4) < dense) begin
                hd  = 1'b1;
                dw  = (($urandom % 3) == 0);
                da  = $urandom & 32'h0000_ffff;
                dwd = $urandom;
                ds  = 3'($urandom);
            end else if (hd && ($urandom % 32) == 0) begin
                hd = 1'b0;
            end
            rv = (($urandom % 150) != 0);
            step(rv, hi, ia, hd, dw, da, dwd, ds, fw, dwn);
            if (fw) hi = 1'b0;
            if (dwn) hd = 1'b0;
        end

        idle(MEM_LAT + 3);
        @(negedge clk);
        #1;
        chk("reads_drained", 32'(rd_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
